// File: rtl/div_unit_pp.sv
// div_unit_pp: iterative restoring divider for the EX stage.
// One quotient bit per cycle, MSB first, on operand magnitudes; signs are
// applied when the last bit is produced. Divide-by-zero skips the iteration
// and reports immediately. Results hold from done until the next accepted start.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for start; results from the previous op held
//   S_RUN  | iterating, busy high, start ignored
//   S_DONE | one-cycle done pulse; start here is accepted back-to-back
module div_unit_pp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder (magnitude)
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dsr_q, dsr_d;     // divisor magnitude
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   shifted;
  logic             trial_ok;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;

  // Magnitudes of the incoming operands; the most negative value maps to
  // 2^(WIDTH-1), which still fits as an unsigned magnitude.
  always_comb begin
    dvd_mag = (signed_op && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    dsr_mag = (signed_op && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
  end

  // One restoring step: the invariant rem < divisor keeps the subtraction
  // result inside WIDTH bits, so only the compare needs the extra bit.
  always_comb begin
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    trial_ok = (shifted >= {1'b0, dsr_q});
    rem_next = trial_ok ? (shifted[WIDTH-1:0] - dsr_q) : shifted[WIDTH-1:0];
    quo_next = {dvd_q[WIDTH-2:0], trial_ok};
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cnt_d = '0;
          if (divisor == '0) begin
            // No iteration: report straight away with the raw dividend.
            state_d = S_DONE;
            quo_d   = '1;
            rmd_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            rem_d   = '0;
            dvd_d   = dvd_mag;
            dsr_d   = dsr_mag;
            qneg_d  = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_d  = signed_op & dividend[WIDTH-1];
            dbz_d   = 1'b0;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        rem_d = rem_next;
        dvd_d = quo_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          // Signed overflow lands here as magnitude 2^(WIDTH-1) with a
          // positive sign, which reads back as -2^(WIDTH-1).
          state_d = S_DONE;
          quo_d   = qneg_q ? (~quo_next + 1'b1) : quo_next;
          rmd_d   = rneg_q ? (~rem_next + 1'b1) : rem_next;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // All state and output flops; synchronous reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit_pp.sv
// tb_div_unit_pp: directed and random divides against an arithmetic model.
module tb_div_unit_pp;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] hold_q = '0;
  logic [W-1:0] hold_r = '0;

  div_unit_pp #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RISC-V division rules in plain integer arithmetic.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    int sa, sb;
    z = (b == 0);
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = '0;
      end else begin
        sa = a;
        sb = b;
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Called at a negedge: drives start for one cycle, scrambles operands while
  // busy, optionally pulses start again at inj_cyc, then checks the result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int inj_cyc);
    logic [W-1:0] eq, er;
    logic         ez;
    int           done_cyc, busy_cnt;
    logic         busy_at_done;
    model(a, b, s, eq, er, ez);
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    signed_op = s;
    done_cyc  = 0;
    busy_cnt  = 0;
    busy_at_done = 1'b1;
    for (int cyc = 1; cyc <= W + 10; cyc++) begin
      @(negedge clk);
      start     = (cyc == inj_cyc);
      dividend  = $urandom;
      divisor   = $urandom;
      signed_op = 1'($urandom);
      if (done) begin
        done_cyc     = cyc;
        busy_at_done = busy;
        break;
      end
      if (busy) busy_cnt++;
      chk("hold_q", quotient, hold_q);
      chk("hold_r", remainder, hold_r);
      chk("dbz_run", {31'b0, div_by_zero}, 32'd0);
    end
    start = 1'b0;
    chk("latency", done_cyc, ez ? 1 : W + 1);
    chk("busy_cycles", busy_cnt, ez ? 0 : W);
    chk("busy_at_done", {31'b0, busy_at_done}, 32'd0);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, ez});
    hold_q = eq;
    hold_r = er;
  endtask

  task automatic reset_mid_op(input logic [W-1:0] a, input logic [W-1:0] b);
    logic saw_done;
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    signed_op = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("busy_before_reset", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    saw_done = 1'b0;
    for (int cyc = 0; cyc < W + 10; cyc++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("no_done_after_reset", {31'b0, saw_done}, 32'd0);
    hold_q = '0;
    hold_r = '0;
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic         s;
    int           pick;

    reset     = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_q", quotient, 32'd0);
    chk("reset_r", remainder, 32'd0);
    chk("reset_dbz", {31'b0, div_by_zero}, 32'd0);

    @(negedge clk); run_op(32'd100, 32'd7, 1'b0, 0);
    @(negedge clk); run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 0);
    @(negedge clk); run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 0);
    @(negedge clk); run_op(32'h0000_1234, 32'd0, 1'b0, 0);
    @(negedge clk); run_op(32'hFFFF_FF9C, 32'd0, 1'b1, 0);
    @(negedge clk); run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    @(negedge clk); run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    @(negedge clk); run_op(32'd5, 32'd9, 1'b0, 0);
    @(negedge clk); run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);

    // Ignored start in RUN, then back-to-back accept in the DONE cycle.
    @(negedge clk); run_op(32'd1000, 32'd33, 1'b0, 5);
    run_op(32'hDEAD_BEEF, 32'h0000_0123, 1'b1, 0);
    run_op(32'h0000_0042, 32'd0, 1'b1, 0);
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 0);

    @(negedge clk); reset_mid_op(32'h0012_3456, 32'd3);
    @(negedge clk); run_op(32'd100, 32'd7, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      s = 1'($urandom);
      case (pick)
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2, 3: b = $urandom_range(1, 20);
        4: b = -($urandom_range(1, 20));
        5: a = $urandom_range(0, 50);
        default: ;
      endcase
      if ($urandom_range(0, 3) != 0) @(negedge clk);
      run_op(a, b, s, ($urandom_range(0, 1) == 1) ? $urandom_range(2, W - 1) : 0);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
